// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// ram_port_arbiter : shares one 16-bit asynchronous SRAM between a fetch port
// and a memory-stage port, splitting each 32-bit access into two half phases.
// Revision: 1.0
// ============================================================================
module ram_port_arbiter #(
  parameter int WAIT         = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [17:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_be,
  input  logic [17:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic [17:0] addr,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic [15:0] data_in,
  output logic        chip_en,
  output logic        oute,
  output logic        wre,
  output logic        hb_mask,
  output logic        lb_mask
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_lo   = 2'd1;
  localparam logic [1:0] c_hi   = 2'd2;
  localparam logic [1:0] c_ack  = 2'd3;

  localparam logic [3:0] c_wait         = 4'(WAIT);
  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  logic [1:0]  r_state;
  logic [3:0]  r_phase;
  logic [3:0]  r_starve;
  logic        r_sel_if;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [16:0] r_word;
  logic [17:0] r_addr;
  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;

  logic w_idle, w_grant_if, w_grant_mem, w_busy, w_hi, w_wr, w_last;
  logic w_unused_ok;

  // Halfword select bit of both request addresses is implied by the phase.
  assign w_unused_ok = &{1'b0, if_addr[0], mem_addr[0]};

  assign w_idle      = (r_state == c_idle);
  assign w_grant_if  = w_idle && if_req && (!mem_req || (r_starve == c_starve_limit));
  assign w_grant_mem = w_idle && mem_req && !w_grant_if;
  assign w_busy      = (r_state == c_lo) || (r_state == c_hi);
  assign w_hi        = (r_state == c_hi);
  assign w_wr        = w_busy && r_we;
  assign w_last      = (r_phase == c_wait);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= c_idle;
      r_phase     <= 4'd0;
      r_sel_if    <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= 4'd0;
      r_wdata     <= 32'd0;
      r_word      <= 17'd0;
      r_addr      <= 18'd0;
      r_if_rdata  <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_grant_if || w_grant_mem) begin
            r_state  <= c_lo;
            r_phase  <= 4'd0;
            r_sel_if <= w_grant_if;
            r_we     <= w_grant_mem && mem_we;
            r_be     <= mem_be;
            r_wdata  <= mem_wdata;
            r_word   <= w_grant_if ? if_addr[17:1] : mem_addr[17:1];
            r_addr   <= {(w_grant_if ? if_addr[17:1] : mem_addr[17:1]), 1'b0};
          end
        end
        c_lo: begin
          if (w_last) begin
            r_state <= c_hi;
            r_phase <= 4'd0;
            r_addr  <= {r_word, 1'b1};
            if (!r_we && r_sel_if)  r_if_rdata[15:0]  <= data_in;
            if (!r_we && !r_sel_if) r_mem_rdata[15:0] <= data_in;
          end else begin
            r_phase <= r_phase + 4'd1;
          end
        end
        c_hi: begin
          if (w_last) begin
            r_state <= c_ack;
            r_phase <= 4'd0;
            if (!r_we && r_sel_if)  r_if_rdata[31:16]  <= data_in;
            if (!r_we && !r_sel_if) r_mem_rdata[31:16] <= data_in;
          end else begin
            r_phase <= r_phase + 4'd1;
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  // Fetch starvation guard: counts mem grants that overrode a pending fetch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else if (w_grant_if) begin
      r_starve <= 4'd0;
    end else if (w_grant_mem && if_req && (r_starve != c_starve_limit)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  assign addr      = r_addr;
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;
  assign if_ack    = (r_state == c_ack) && r_sel_if;
  assign mem_ack   = (r_state == c_ack) && !r_sel_if;
  assign chip_en   = !w_busy;
  assign oute      = !(w_busy && !r_we);
  // Write strobe rises in the final cycle so data is stable across its trailing edge.
  assign wre       = !(w_wr && !w_last);
  assign data_oe   = w_wr;
  assign data_out  = !w_wr ? 16'h0000 : (w_hi ? r_wdata[31:16] : r_wdata[15:0]);
  assign lb_mask   = !w_busy || (r_we && !(w_hi ? r_be[2] : r_be[0]));
  assign hb_mask   = !w_busy || (r_we && !(w_hi ? r_be[3] : r_be[1]));

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// Directed bench for ram_port_arbiter: table of single transactions plus
// starvation, mid-access reset and WAIT=3 sequences.
module tb_ram_port_arbiter;

  localparam int c_wait = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [17:0] if_addr = '0, mem_addr = '0;
  logic [3:0]  mem_be = '0;
  logic [31:0] mem_wdata = '0;
  logic        if_ack, mem_ack, data_oe, chip_en, oute, wre, hb_mask, lb_mask;
  logic [31:0] if_rdata, mem_rdata;
  logic [17:0] addr;
  logic [15:0] data_out, data_in;

  logic        w3_if_req = 1'b0, w3_mem_req = 1'b0, w3_mem_we = 1'b0;
  logic [17:0] w3_if_addr = '0, w3_mem_addr = '0;
  logic [3:0]  w3_mem_be = '0;
  logic [31:0] w3_mem_wdata = '0;
  logic        w3_if_ack, w3_mem_ack, w3_data_oe, w3_chip_en, w3_oute, w3_wre, w3_hb_mask, w3_lb_mask;
  logic [31:0] w3_if_rdata, w3_mem_rdata;
  logic [17:0] w3_addr;
  logic [15:0] w3_data_out, w3_data_in;

  function automatic logic [15:0] ram_rd(input logic [17:0] a);
    case (a)
      18'h00010: return 16'h1234;
      18'h00011: return 16'hABCD;
      default:   return a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  assign data_in    = ram_rd(addr);
  assign w3_data_in = ram_rd(w3_addr);

  ram_port_arbiter #(.WAIT(c_wait), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .addr(addr), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .chip_en(chip_en), .oute(oute), .wre(wre), .hb_mask(hb_mask), .lb_mask(lb_mask)
  );

  ram_port_arbiter #(.WAIT(3), .STARVE_LIMIT(4)) dut3 (
    .clock(clock), .reset(reset),
    .if_req(w3_if_req), .if_addr(w3_if_addr), .if_ack(w3_if_ack), .if_rdata(w3_if_rdata),
    .mem_req(w3_mem_req), .mem_we(w3_mem_we), .mem_be(w3_mem_be), .mem_addr(w3_mem_addr),
    .mem_wdata(w3_mem_wdata), .mem_ack(w3_mem_ack), .mem_rdata(w3_mem_rdata),
    .addr(w3_addr), .data_out(w3_data_out), .data_oe(w3_data_oe), .data_in(w3_data_in),
    .chip_en(w3_chip_en), .oute(w3_oute), .wre(w3_wre), .hb_mask(w3_hb_mask), .lb_mask(w3_lb_mask)
  );

  typedef struct {
    string       name;
    logic        is_mem;
    logic        we;
    logic [3:0]  be;
    logic [17:0] a;
    logic [31:0] wdata;
    logic [17:0] lo_addr;
    logic [17:0] hi_addr;
    logic [1:0]  lo_mask;   // {hb_mask, lb_mask}
    logic [1:0]  hi_mask;
    logic [31:0] exp_if;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs[9];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(string n, logic is_mem, logic we, logic [3:0] be,
                              logic [17:0] a, logic [31:0] wd, logic [17:0] lo,
                              logic [17:0] hi, logic [1:0] lm, logic [1:0] hm,
                              logic [31:0] ifr, logic [31:0] memr);
    vec_t v;
    v.name = n; v.is_mem = is_mem; v.we = we; v.be = be; v.a = a; v.wdata = wd;
    v.lo_addr = lo; v.hi_addr = hi; v.lo_mask = lm; v.hi_mask = hm;
    v.exp_if = ifr; v.exp_mem = memr;
    return v;
  endfunction

  // {chip_en, oute, wre, data_oe, hb_mask, lb_mask, if_ack, mem_ack}
  function logic [7:0] strb();
    return {chip_en, oute, wre, data_oe, hb_mask, lb_mask, if_ack, mem_ack};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] exp_s;
    logic       in_hi, last;
    @(negedge clock);
    chk({v.name, " idle strobes"}, {24'd0, strb()}, 32'hEC);
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_be = v.be; mem_addr = v.a; mem_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.a;
    end
    for (int c = 1; c <= 2*c_wait+3; c++) begin
      @(negedge clock);
      if (c == 2*c_wait+3) begin
        chk($sformatf("%s ack strobes", v.name), {24'd0, strb()}, v.is_mem ? 32'hED : 32'hEE);
        chk($sformatf("%s ack addr", v.name), {14'd0, addr}, {14'd0, v.hi_addr});
        chk($sformatf("%s if_rdata", v.name), if_rdata, v.exp_if);
        chk($sformatf("%s mem_rdata", v.name), mem_rdata, v.exp_mem);
        if_req = 1'b0; mem_req = 1'b0;
      end else begin
        in_hi = (c > c_wait+1);
        last  = (c == c_wait+1) || (c == 2*c_wait+2);
        if (v.we) exp_s = {1'b0, 1'b1, last, 1'b1, (in_hi ? v.hi_mask : v.lo_mask), 2'b00};
        else      exp_s = 8'h20;
        chk($sformatf("%s c%0d strobes", v.name, c), {24'd0, strb()}, {24'd0, exp_s});
        chk($sformatf("%s c%0d addr", v.name, c), {14'd0, addr},
            {14'd0, (in_hi ? v.hi_addr : v.lo_addr)});
        if (v.we)
          chk($sformatf("%s c%0d data_out", v.name, c), {16'd0, data_out},
              {16'd0, (in_hi ? v.wdata[31:16] : v.wdata[15:0])});
      end
    end
    @(negedge clock);
    chk({v.name, " post strobes"}, {24'd0, strb()}, 32'hEC);
    chk({v.name, " post addr held"}, {14'd0, addr}, {14'd0, v.hi_addr});
  endtask

  initial begin
    logic [9:0] exp_order;
    logic       dual, ack_seen;
    int         n, cyc;

    vecs[0] = mk("fetch_rd_11",  1'b0, 1'b0, 4'h0,    18'h00011, 32'h0,        18'h00010, 18'h00011, 2'b00, 2'b00, 32'hABCD1234, 32'h0);
    vecs[1] = mk("mem_rd_40",    1'b1, 1'b0, 4'h0,    18'h00040, 32'h0,        18'h00040, 18'h00041, 2'b00, 2'b00, 32'hABCD1234, 32'h5A1B5A1A);
    vecs[2] = mk("mem_wr_be6",   1'b1, 1'b1, 4'b0110, 18'h00020, 32'hDEADBEEF, 18'h00020, 18'h00021, 2'b01, 2'b10, 32'hABCD1234, 32'h5A1B5A1A);
    vecs[3] = mk("mem_wr_be0",   1'b1, 1'b1, 4'b0000, 18'h00021, 32'h12345678, 18'h00020, 18'h00021, 2'b11, 2'b11, 32'hABCD1234, 32'h5A1B5A1A);
    vecs[4] = mk("mem_wr_beF",   1'b1, 1'b1, 4'b1111, 18'h00030, 32'hA5A55A5A, 18'h00030, 18'h00031, 2'b00, 2'b00, 32'hABCD1234, 32'h5A1B5A1A);
    vecs[5] = mk("fetch_rd_top", 1'b0, 1'b0, 4'h0,    18'h3FFFE, 32'h0,        18'h3FFFE, 18'h3FFFF, 2'b00, 2'b00, 32'hA5A5A5A4, 32'h5A1B5A1A);
    vecs[6] = mk("mem_rd_top",   1'b1, 1'b0, 4'h0,    18'h3FFFF, 32'h0,        18'h3FFFE, 18'h3FFFF, 2'b00, 2'b00, 32'hA5A5A5A4, 32'hA5A5A5A4);
    vecs[7] = mk("fetch_rd_100", 1'b0, 1'b0, 4'h0,    18'h00100, 32'h0,        18'h00100, 18'h00101, 2'b00, 2'b00, 32'h5B5B5B5A, 32'hA5A5A5A4);
    vecs[8] = mk("fetch_post_rst", 1'b0, 1'b0, 4'h0,  18'h00011, 32'h0,        18'h00010, 18'h00011, 2'b00, 2'b00, 32'hABCD1234, 32'h0);

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("reset strobes", {24'd0, strb()}, 32'hEC);
    chk("reset addr", {14'd0, addr}, 32'd0);
    chk("reset data_out", {16'd0, data_out}, 32'd0);
    chk("reset rdata", if_rdata | mem_rdata, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Both ports held: four mem grants then one fetch, repeating
    exp_order = 10'b10000_10000;
    dual = 1'b0; n = 0; cyc = 0;
    @(negedge clock);
    if_req = 1'b1; if_addr = 18'h00100;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00040;
    while (n < 10 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (if_ack && mem_ack) dual = 1'b1;
      if (if_ack || mem_ack) begin
        chk($sformatf("starve grant %0d is fetch", n), {31'd0, if_ack}, {31'd0, exp_order[n]});
        n++;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("starve grant count", n, 10);
    chk("starve dual ack", {31'd0, dual}, 32'd0);
    chk("starve if_rdata", if_rdata, 32'h5B5B5B5A);
    chk("starve mem_rdata", mem_rdata, 32'h5A1B5A1A);

    // Reset in the second cycle of HI during a write
    @(negedge clock);
    @(negedge clock);
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'hF; mem_addr = 18'h00050; mem_wdata = 32'hCAFEF00D;
    repeat (c_wait+3) @(negedge clock);
    chk("midrst pre data_oe", {31'd0, data_oe}, 32'd1);
    chk("midrst pre addr", {14'd0, addr}, 32'h51);
    reset = 1'b1; mem_req = 1'b0;
    #1;
    chk("midrst strobes", {24'd0, strb()}, 32'hEC);
    chk("midrst addr", {14'd0, addr}, 32'd0);
    chk("midrst data_out", {16'd0, data_out}, 32'd0);
    chk("midrst rdata", if_rdata | mem_rdata, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    ack_seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (if_ack || mem_ack) ack_seen = 1'b1;
    end
    chk("midrst no ack", {31'd0, ack_seen}, 32'd0);
    run_vec(vecs[8]);

    // WAIT=3 read at the top of the address space
    @(negedge clock);
    w3_if_req = 1'b1; w3_if_addr = 18'h3FFFE;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      if (c <= 4)
        chk($sformatf("w3 c%0d", c), {10'd0, w3_chip_en, w3_oute, w3_if_ack, w3_mem_ack, w3_addr}, {14'd0, 18'h3FFFE});
      else if (c <= 8)
        chk($sformatf("w3 c%0d", c), {10'd0, w3_chip_en, w3_oute, w3_if_ack, w3_mem_ack, w3_addr}, {14'd0, 18'h3FFFF});
      else begin
        chk("w3 ack", {10'd0, w3_chip_en, w3_oute, w3_if_ack, w3_mem_ack, w3_addr}, {10'd0, 4'b1110, 18'h3FFFF});
        chk("w3 if_rdata", w3_if_rdata, 32'hA5A5A5A4);
        w3_if_req = 1'b0;
      end
    end
    @(negedge clock);
    chk("w3 post ack", {30'd0, w3_if_ack, w3_mem_ack}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter WAIT, default 1, cycles a RAM control strobe is held per 16-bit half access (legal 1..15).
REQ-002 Parameter STARVE_LIMIT, default 4, number of consecutive memory-port grants after which a pending fetch request wins (legal 1..15).
REQ-003 Port clock  in  1  single clock; all state changes on posedge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port if_req  in  1  fetch read request, held until if_ack.
REQ-006 Port if_addr  in  18  fetch halfword address; bit 0 ignored.
REQ-007 Port if_ack  out  1  one-cycle pulse: fetch word complete.
REQ-008 Port if_rdata  out  32  fetch read word, {high half, low half}.
REQ-009 Port mem_req  in  1  memory-stage request, held until mem_ack.
REQ-010 Port mem_we  in  1  1 = write, 0 = read.
REQ-011 Port mem_be  in  4  write byte enables, bit 0 = byte 0 (LSB).
REQ-012 Port mem_addr  in  18  memory-stage halfword address; bit 0 ignored.
REQ-013 Port mem_wdata  in  32  write word.
REQ-014 Port mem_ack  out  1  one-cycle pulse: memory access complete.
REQ-015 Port mem_rdata  out  32  memory-stage read word.
REQ-016 Port addr  out  18  SRAM address.
REQ-017 Port data_out  out  16  SRAM write data; data_oe  out  1  pad tri-state enable.
REQ-018 Port data_in  in  16  SRAM read data.
REQ-019 Port chip_en, oute, wre, hb_mask, lb_mask  out  1 each  SRAM controls, all active-low.

Function
REQ-020 The FSM SHALL have states IDLE, LO, HI, ACK; LO and HI each last WAIT+1 cycles, counted by a 4-bit phase counter; ACK lasts 1 cycle.
REQ-021 In IDLE, requests SHALL be sampled on each edge; if only one is high it is granted; if both are high, mem wins unless the starvation counter equals STARVE_LIMIT, in which case fetch wins.
REQ-022 The starvation counter SHALL increment on each mem grant made while if_req is high, saturate at STARVE_LIMIT, and clear on any fetch grant.
REQ-023 On grant, the address, we, be and wdata SHALL be latched; base = {addr[17:1],1'b0}; LO accesses base, HI accesses base+1.
REQ-024 During LO and HI: chip_en = 0; addr = phase address; read: oute = 0, wre = 1, data_oe = 0.
REQ-025 Write phases: oute = 1, data_oe = 1, data_out = the phase half of wdata, wre = 0 for the first WAIT cycles and 1 in the final cycle of the phase.
REQ-026 Write masks SHALL be: LO lb_mask = ~be[0], hb_mask = ~be[1]; HI lb_mask = ~be[2], hb_mask = ~be[3]; reads drive both masks 0.
REQ-027 Reads SHALL capture data_in in the final cycle of LO into the low half and of HI into the high half of the granted port's rdata register.
REQ-028 In ACK the granted port's ack SHALL be 1 for exactly one cycle; the FSM then returns to IDLE; only one ack is ever high at a time.
REQ-029 Latency: ack SHALL be high 2*WAIT+3 cycles after the granting edge (WAIT=1: 5 cycles).
REQ-030 if_rdata and mem_rdata SHALL hold their last value until overwritten by the next read on that port; writes leave mem_rdata unchanged.
REQ-031 In IDLE and ACK: chip_en, oute, wre, hb_mask, lb_mask = 1; data_oe = 0; addr holds its last value.
REQ-032 Requests arriving outside IDLE SHALL be ignored until IDLE; a req still high in the IDLE cycle after ack is a new request.
REQ-033 Address base 0x3FFFE SHALL access 0x3FFFE then 0x3FFFF; the block never carries beyond 18 bits.
REQ-034 mem_we = 1 with mem_be = 0 SHALL still execute both phases with both masks at 1 and return mem_ack.

Reset
REQ-035 Asserting reset SHALL, at any time including mid-phase, force state IDLE, phase and starvation counters 0, addr 0, data_out 0, data_oe 0, all active-low strobes 1, acks 0, and both rdata registers 0; an interrupted access produces no ack.

Verification
REQ-036 Fetch-only, WAIT=1, if_addr=0x00011, RAM[0x10]=0x1234, RAM[0x11]=0xABCD -> addr 0x10 then 0x11, oute low 4 cycles, if_ack 5 cycles after grant, if_rdata=0xABCD1234.
REQ-037 Write, mem_addr=0x20, mem_be=4'b0110, wdata=0xDEADBEEF -> LO: lb_mask=1, hb_mask=0, data_out=0xBEEF; HI: lb_mask=0, hb_mask=1, data_out=0xDEAD; wre low 1 cycle per phase; mem_ack; mem_rdata unchanged.
REQ-038 Both requests held continuously, STARVE_LIMIT=4 -> grant order mem,mem,mem,mem,fetch, repeating; never two acks in one cycle.
REQ-039 WAIT=3, read at base 0x3FFFE -> each phase 4 cycles, addr 0x3FFFE then 0x3FFFF, ack 9 cycles after grant.
REQ-040 Reset asserted in the second cycle of HI during a write -> strobes 1 and data_oe 0 immediately (asynchronous), no mem_ack; after release, a new fetch completes normally.
